// File: rtl/pci_tgt_pkg.sv
// Shared types for the PCI target responder.
// State encoding, termination codes and parameter defaults.
package pci_tgt_pkg;

  localparam int CBE_W         = 4;
  localparam int AW_DEF        = 6;
  localparam int WAIT_DEF      = 2;
  localparam int MAX_BURST_DEF = 8;
  localparam int BAR_SEL_DEF   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_XFER,
    ST_RETRY,
    ST_ABORT
  } tgt_state_e;

  typedef enum logic [1:0] {
    TERM_NONE,
    TERM_RETRY,
    TERM_DISC,
    TERM_ABORT
  } term_e;

  // Returns {s_term, s_abort} for a termination code.
  function automatic logic [1:0] term_bits(input term_e t);
    logic [1:0] r;
    case (t)
      TERM_RETRY: r = 2'b10;
      TERM_DISC:  r = 2'b10;
      TERM_ABORT: r = 2'b11;
      default:    r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tgt_bytemem.sv
// Target backing store: 2^AW x 32 RAM, byte-lane writes,
// registered read port that can be forced to zero.
module tgt_bytemem
  import pci_tgt_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [CBE_W-1:0] we,
  input  logic [AW-1:0]    waddr,
  input  logic [31:0]      wdata,
  input  logic [AW-1:0]    raddr,
  input  logic             rd_clr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge CLK) begin
    for (int b = 0; b < CBE_W; b++) begin
      if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (rd_clr) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/target_responder.sv
// User-side PCI target: one BAR, linear bursts, wait states,
// retry / disconnect / abort termination.
module target_responder
  import pci_tgt_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int WAIT      = WAIT_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int BAR_SEL   = BAR_SEL_DEF
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [7:0]       base_hit,
  input  logic             addr_vld,
  input  logic [31:0]      adio_out,
  input  logic             s_wrdn,
  input  logic             s_data,
  input  logic             s_data_vld,
  input  logic             s_src_en,
  input  logic [CBE_W-1:0] s_cbe,
  input  logic             cfg_retry,
  output logic [31:0]      adio_in,
  output logic             s_ready,
  output logic             s_term,
  output logic             s_abort,
  output logic [15:0]      xfer_cnt
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int WW = $clog2(WAIT + 2);

  tgt_state_e       state;
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    ptr_n;
  logic             dir;
  logic             seen;
  logic [BW-1:0]    beat;
  logic [WW-1:0]    wcnt;
  logic             hit;
  logic             addr_go;
  logic             bad_align;
  logic             go_xfer;
  logic             wait_done;
  logic             leave;
  logic             beat_ok;
  logic             adv;
  logic             rd_next;
  logic [CBE_W-1:0] we;

  assign hit       = |(base_hit & (8'd1 << BAR_SEL));
  assign addr_go   = state == ST_IDLE && addr_vld && hit;
  assign bad_align = adio_out[1:0] != 2'b00;
  assign go_xfer   = addr_go && !cfg_retry && !bad_align
                     && WAIT == 0;
  assign wait_done = state == ST_WAIT && s_data && wcnt == '0;
  assign leave     = seen && !s_data;
  assign beat_ok   = state == ST_XFER && s_ready && s_data_vld;
  assign adv       = state == ST_XFER
                     && (dir ? beat_ok : s_src_en);
  assign we        = (beat_ok && dir) ? ~s_cbe : '0;

  // Read port is addressed one cycle ahead so data is valid
  // on the first XFER cycle and right after each s_src_en.
  assign rd_next = (go_xfer && !s_wrdn)
                   || (wait_done && !dir)
                   || (state == ST_XFER && !dir && !leave);

  always_comb begin
    ptr_n = ptr;
    unique case (1'b1)
      addr_go: ptr_n = adio_out[AW+1:2];
      adv:     ptr_n = ptr + 1'b1;
      default: ;
    endcase
  end

  tgt_bytemem #(
    .AW(AW)
  ) u_mem (
    .CLK    (CLK),
    .reset  (reset),
    .we     (we),
    .waddr  (ptr),
    .wdata  (adio_out),
    .raddr  (ptr_n),
    .rd_clr (!rd_next),
    .rdata  (adio_in)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      dir      <= 1'b0;
      seen     <= 1'b0;
      beat     <= '0;
      wcnt     <= '0;
      s_ready  <= 1'b0;
      s_term   <= 1'b0;
      s_abort  <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      ptr <= ptr_n;
      if (beat_ok) xfer_cnt <= xfer_cnt + 16'd1;
      unique case (state)
        ST_IDLE: begin
          seen <= 1'b0;
          if (addr_go) begin
            dir  <= s_wrdn;
            beat <= '0;
            wcnt <= WW'(WAIT);
            priority case (1'b1)
              cfg_retry: begin
                state <= ST_RETRY;
                {s_term, s_abort} <= term_bits(TERM_RETRY);
              end
              bad_align: begin
                state <= ST_ABORT;
                {s_term, s_abort} <= term_bits(TERM_ABORT);
              end
              go_xfer: begin
                state   <= ST_XFER;
                s_ready <= 1'b1;
              end
              default: state <= ST_WAIT;
            endcase
          end
        end
        ST_WAIT: begin
          if (s_data) begin
            seen <= 1'b1;
            if (wcnt == '0) begin
              state   <= ST_XFER;
              s_ready <= 1'b1;
            end else begin
              wcnt <= wcnt - 1'b1;
            end
          end else if (seen) begin
            state <= ST_IDLE;
          end
        end
        ST_XFER: begin
          if (leave) begin
            state   <= ST_IDLE;
            s_ready <= 1'b0;
            {s_term, s_abort} <= term_bits(TERM_NONE);
          end else begin
            if (s_data) seen <= 1'b1;
            // Disconnect-with-data: the beat after the threshold
            // still completes, then s_ready drops.
            if (beat_ok) begin
              beat <= beat + 1'b1;
              if (beat + 1'b1 == BW'(MAX_BURST - 1))
                {s_term, s_abort} <= term_bits(TERM_DISC);
              if (beat + 1'b1 == BW'(MAX_BURST))
                s_ready <= 1'b0;
            end
          end
        end
        ST_RETRY, ST_ABORT: begin
          if (leave) begin
            state <= ST_IDLE;
            {s_term, s_abort} <= term_bits(TERM_NONE);
          end else if (s_data) begin
            seen <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_target_responder.sv
// Bench for target_responder: directed cases plus random
// transactions against a word-array reference model.
module tb_target_responder;

  localparam int AW    = 6;
  localparam int WT    = 2;
  localparam int MB    = 8;
  localparam int DEPTH = 1 << AW;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  base_hit = '0;
  logic        addr_vld = 1'b0;
  logic [31:0] adio_out = '0;
  logic        s_wrdn = 1'b0;
  logic        s_data = 1'b0;
  logic        s_data_vld = 1'b0;
  logic        s_src_en = 1'b0;
  logic [3:0]  s_cbe = 4'hF;
  logic        cfg_retry = 1'b0;
  logic [31:0] adio_in;
  logic        s_ready;
  logic        s_term;
  logic        s_abort;
  logic [15:0] xfer_cnt;

  int n_chk = 0;
  int n_err = 0;
  int cnt = 0;

  logic [31:0] ref_mem [DEPTH];
  bit          known [DEPTH];
  logic [31:0] wbuf [16];
  logic [31:0] rbuf [16];

  always #5 CLK = ~CLK;

  target_responder #(
    .AW(AW), .WAIT(WT), .MAX_BURST(MB), .BAR_SEL(0)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .base_hit   (base_hit),
    .addr_vld   (addr_vld),
    .adio_out   (adio_out),
    .s_wrdn     (s_wrdn),
    .s_data     (s_data),
    .s_data_vld (s_data_vld),
    .s_src_en   (s_src_en),
    .s_cbe      (s_cbe),
    .cfg_retry  (cfg_retry),
    .adio_in    (adio_in),
    .s_ready    (s_ready),
    .s_term     (s_term),
    .s_abort    (s_abort),
    .xfer_cnt   (xfer_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Core-side model of one normal transaction.
  task automatic txn(input bit wr, input int word, input int n,
                     input logic [3:0] cbe, input int rst_after);
    int k, cyc, rdy_at, term_k, w, exp_k;
    bit disc;
    @(negedge CLK);
    addr_vld = 1'b1;
    base_hit = 8'h01;
    s_wrdn = wr;
    adio_out = 32'(word) << 2;
    @(negedge CLK);
    addr_vld = 1'b0;
    base_hit = '0;
    adio_out = '0;
    s_data = 1'b1;
    k = 0; cyc = 0; rdy_at = -1; term_k = -1; disc = 0;
    while (k < n && !disc && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      s_data_vld = 1'b0;
      s_src_en = 1'b0;
      s_cbe = 4'hF;
      if (k == rst_after) break;
      if (s_ready) begin
        if (rdy_at < 0) rdy_at = cyc;
        if (s_term) begin
          disc = 1;
          term_k = k;
        end
        s_data_vld = 1'b1;
        s_src_en = !wr;
        s_cbe = cbe;
        adio_out = wbuf[k];
        rbuf[k] = adio_in;
        k++;
      end
    end
    if (rst_after >= 0) begin
      s_data = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst_outs", 32'({s_ready, s_term, s_abort}), 32'd0);
      chk("rst_adio", adio_in, 32'd0);
      chk("rst_cnt", 32'(xfer_cnt), 32'd0);
      cnt = 0;
      @(negedge CLK);
      reset = 1'b0;
    end else begin
      exp_k = (n < MB) ? n : MB;
      chk("beats", k, exp_k);
      chk("rdy_lat", rdy_at, WT + 1);
      chk("disc_beat", term_k, (n >= MB) ? MB - 1 : -1);
      @(negedge CLK);
      s_data_vld = 1'b0;
      s_src_en = 1'b0;
      s_data = 1'b0;
      @(negedge CLK);
      chk("idle_outs", 32'({s_ready, s_term, s_abort}), 32'd0);
      chk("idle_adio", adio_in, 32'd0);
      cnt += k;
    end
    for (int i = 0; i < k; i++) begin
      w = (word + i) % DEPTH;
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (!cbe[b]) ref_mem[w][8*b +: 8] = wbuf[i][8*b +: 8];
        if (cbe == 4'h0) known[w] = 1;
      end else if (known[w]) begin
        chk("rd_data", rbuf[i], ref_mem[w]);
      end
    end
    chk("xfer_cnt", 32'(xfer_cnt), 32'(cnt[15:0]));
  endtask

  // Retry or abort: core still drives a junk beat, which
  // must not reach memory.
  task automatic term_txn(input int word, input logic [1:0] lo,
                          input bit rty);
    bit ab;
    ab = !rty && lo != 2'b00;
    @(negedge CLK);
    addr_vld = 1'b1;
    base_hit = 8'h01;
    s_wrdn = 1'b1;
    cfg_retry = rty;
    adio_out = (32'(word) << 2) | 32'(lo);
    @(negedge CLK);
    addr_vld = 1'b0;
    base_hit = '0;
    cfg_retry = 1'b0;
    s_data = 1'b1;
    chk("trm_outs", 32'({s_ready, s_term, s_abort}),
        32'({1'b0, 1'b1, ab}));
    s_data_vld = 1'b1;
    s_cbe = 4'h0;
    adio_out = $urandom;
    @(negedge CLK);
    chk("trm_hold", 32'({s_ready, s_term, s_abort}),
        32'({1'b0, 1'b1, ab}));
    s_data_vld = 1'b0;
    s_cbe = 4'hF;
    s_data = 1'b0;
    @(negedge CLK);
    chk("trm_idle", 32'({s_ready, s_term, s_abort}), 32'd0);
    chk("trm_cnt", 32'(xfer_cnt), 32'(cnt[15:0]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int r;
    repeat (2) @(negedge CLK);
    chk("reset_outs", 32'({s_ready, s_term, s_abort}), 32'd0);
    chk("reset_adio", adio_in, 32'd0);
    chk("reset_cnt", 32'(xfer_cnt), 32'd0);
    reset = 1'b0;

    // single write then readback
    wbuf[0] = 32'h1234_5678;
    txn(1, 3, 1, 4'h0, -1);
    txn(0, 3, 1, 4'h0, -1);
    chk("t1_rd", rbuf[0], 32'h1234_5678);
    chk("t1_cnt", 32'(xfer_cnt), 32'd2);

    // byte enables
    wbuf[0] = 32'h0;
    txn(1, 5, 1, 4'h0, -1);
    wbuf[0] = 32'hFFFF_FFFF;
    txn(1, 5, 1, 4'b1010, -1);
    txn(0, 5, 1, 4'h0, -1);
    chk("be_rd", rbuf[0], 32'h00FF_00FF);

    // fill memory with full-word bursts
    for (int b = 0; b < DEPTH / MB; b++) begin
      for (int i = 0; i < MB; i++) wbuf[i] = $urandom;
      txn(1, b * MB, MB, 4'h0, -1);
    end

    // read burst of 10 -> disconnect after 8
    txn(0, 0, 10, 4'h0, -1);

    // wrap at top of memory
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA000_0000 + 32'(i);
    txn(1, 62, 4, 4'h0, -1);
    txn(0, 62, 4, 4'h0, -1);
    chk("wrap_rd", rbuf[2], 32'hA000_0002);

    // retry, abort, retry beats abort
    term_txn(10, 2'b00, 1);
    term_txn(11, 2'b10, 0);
    term_txn(12, 2'b01, 1);
    txn(0, 10, 3, 4'h0, -1);

    // non-selected BAR is ignored
    @(negedge CLK);
    addr_vld = 1'b1;
    base_hit = 8'h02;
    adio_out = 32'h10;
    @(negedge CLK);
    addr_vld = 1'b0;
    base_hit = '0;
    s_data = 1'b1;
    repeat (4) @(negedge CLK);
    chk("nohit_outs", 32'({s_ready, s_term, s_abort}), 32'd0);
    s_data = 1'b0;
    @(negedge CLK);

    // reset mid-burst, then normal traffic
    for (int i = 0; i < 6; i++) wbuf[i] = 32'hC0DE_0000 + 32'(i);
    txn(1, 20, 6, 4'h0, 2);
    txn(0, 20, 3, 4'h0, -1);
    chk("post_rst_rd", rbuf[1], 32'hC0DE_0001);

    for (int t = 0; t < 24; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        term_txn($urandom_range(0, DEPTH - 1),
                 2'($urandom_range(0, 3)), 1);
      end else if (r == 1) begin
        term_txn($urandom_range(0, DEPTH - 1),
                 2'($urandom_range(1, 3)), 0);
      end else begin
        for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
        txn(1'($urandom_range(0, 1)),
            $urandom_range(0, DEPTH - 1),
            $urandom_range(1, 10),
            4'($urandom_range(0, 15)), -1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
